// File: rtl/tap_pkg.sv
// -----------------------------------------------------------------------------
// tap_pkg
// Shared definitions for the boundary-scan TAP controller:
//   - 4-bit encodings of the 16 TAP FSM states (TLR .. UpdIR)
//   - default instruction register width
//   - helper that flags the two shift states
// -----------------------------------------------------------------------------
package tap_pkg;

  localparam int STATE_W  = 4;
  localparam int DEF_IR_W = 4;

  typedef logic [STATE_W-1:0] tap_state_t;

  localparam tap_state_t ST_TLR      = 4'd0;
  localparam tap_state_t ST_RTI      = 4'd1;
  localparam tap_state_t ST_SEL_DR   = 4'd2;
  localparam tap_state_t ST_CAP_DR   = 4'd3;
  localparam tap_state_t ST_SH_DR    = 4'd4;
  localparam tap_state_t ST_EX1_DR   = 4'd5;
  localparam tap_state_t ST_PAUSE_DR = 4'd6;
  localparam tap_state_t ST_EX2_DR   = 4'd7;
  localparam tap_state_t ST_UPD_DR   = 4'd8;
  localparam tap_state_t ST_SEL_IR   = 4'd9;
  localparam tap_state_t ST_CAP_IR   = 4'd10;
  localparam tap_state_t ST_SH_IR    = 4'd11;
  localparam tap_state_t ST_EX1_IR   = 4'd12;
  localparam tap_state_t ST_PAUSE_IR = 4'd13;
  localparam tap_state_t ST_EX2_IR   = 4'd14;
  localparam tap_state_t ST_UPD_IR   = 4'd15;

  // True in the two states where TDO carries scan data.
  function automatic logic is_shift_state(input tap_state_t st);
    return (st == ST_SH_DR) || (st == ST_SH_IR);
  endfunction

endpackage

// File: rtl/tap_fsm.sv
// -----------------------------------------------------------------------------
// tap_fsm
// 16-state TAP state machine, advanced on the rising edge of TCK from TMS.
// Ports:
//   tck_i    test clock
//   rst_ni   asynchronous active-low reset (forces Test-Logic-Reset)
//   tms_i    mode select
//   state_o  current state encoding (tap_pkg::ST_*)
// -----------------------------------------------------------------------------
module tap_fsm
  import tap_pkg::*;
(
  input  logic       tck_i,
  input  logic       rst_ni,
  input  logic       tms_i,
  output tap_state_t state_o
);

  tap_state_t state_q;
  tap_state_t state_d;

  // Next-state table; the IR branch mirrors the DR branch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_TLR:      state_d = tms_i ? ST_TLR      : ST_RTI;
      ST_RTI:      state_d = tms_i ? ST_SEL_DR   : ST_RTI;
      ST_SEL_DR:   state_d = tms_i ? ST_SEL_IR   : ST_CAP_DR;
      ST_CAP_DR:   state_d = tms_i ? ST_EX1_DR   : ST_SH_DR;
      ST_SH_DR:    state_d = tms_i ? ST_EX1_DR   : ST_SH_DR;
      ST_EX1_DR:   state_d = tms_i ? ST_UPD_DR   : ST_PAUSE_DR;
      ST_PAUSE_DR: state_d = tms_i ? ST_EX2_DR   : ST_PAUSE_DR;
      ST_EX2_DR:   state_d = tms_i ? ST_UPD_DR   : ST_SH_DR;
      ST_UPD_DR:   state_d = tms_i ? ST_SEL_DR   : ST_RTI;
      ST_SEL_IR:   state_d = tms_i ? ST_TLR      : ST_CAP_IR;
      ST_CAP_IR:   state_d = tms_i ? ST_EX1_IR   : ST_SH_IR;
      ST_SH_IR:    state_d = tms_i ? ST_EX1_IR   : ST_SH_IR;
      ST_EX1_IR:   state_d = tms_i ? ST_UPD_IR   : ST_PAUSE_IR;
      ST_PAUSE_IR: state_d = tms_i ? ST_EX2_IR   : ST_PAUSE_IR;
      ST_EX2_IR:   state_d = tms_i ? ST_UPD_IR   : ST_SH_IR;
      ST_UPD_IR:   state_d = tms_i ? ST_SEL_DR   : ST_RTI;
      default:     state_d = ST_TLR;
    endcase
  end

  // State register.
  always_ff @(posedge tck_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_TLR;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/tap_controller.sv
// -----------------------------------------------------------------------------
// tap_controller
// Boundary-scan TAP controller sequencing a chain of BC1 cells.
// Ports:
//   TCK       test clock (only clock)
//   Reset     asynchronous active-low reset
//   TMS       mode select, sampled on rising TCK
//   TDI       serial in to IR / bypass
//   BR_TDO    serial out of the last BC1 cell
//   TDO       serial out, updated on falling TCK
//   TDO_En    high while in a shift state (updated on falling TCK)
//   ShiftBR   BC1 shift/capture select
//   ClockBR   gated TCK for the BC1 capture/shift flops
//   UpdateBR  BC1 update strobe (low half of Update-DR)
//   ModeCont  BC1 output mux select (EXTEST active)
//   TapState  current FSM state for debug
// -----------------------------------------------------------------------------
module tap_controller
  import tap_pkg::*;
#(
  parameter int              IR_W      = DEF_IR_W,
  parameter logic [IR_W-1:0] OP_EXTEST = {IR_W{1'b0}},
  parameter logic [IR_W-1:0] OP_SAMPLE = {{(IR_W-1){1'b0}}, 1'b1},
  parameter logic [IR_W-1:0] OP_BYPASS = {IR_W{1'b1}}
) (
  input  logic       TCK,
  input  logic       Reset,
  input  logic       TMS,
  input  logic       TDI,
  input  logic       BR_TDO,
  output logic       TDO,
  output logic       TDO_En,
  output logic       ShiftBR,
  output logic       ClockBR,
  output logic       UpdateBR,
  output logic       ModeCont,
  output logic [3:0] TapState
);

  localparam logic [IR_W-1:0] IR_CAPTURE = {{(IR_W-2){1'b0}}, 2'b01};

  tap_state_t      state_s;
  logic            br_sel_s;
  logic            in_sh_dr_s;

  logic [IR_W-1:0] ir_q, ir_d;
  logic [IR_W-1:0] instr_q, instr_d;
  logic            byp_q, byp_d;
  logic            mode_q, mode_d;
  logic            tdo_q, tdo_d;
  logic            tdo_en_q, tdo_en_d;
  logic            clk_en_q, clk_en_d;

  tap_fsm u_fsm (
    .tck_i   (TCK),
    .rst_ni  (Reset),
    .tms_i   (TMS),
    .state_o (state_s)
  );

  // Undefined opcodes fall through to bypass.
  assign br_sel_s   = (instr_q == OP_EXTEST) || (instr_q == OP_SAMPLE);
  assign in_sh_dr_s = (state_s == ST_SH_DR);

  // IR shift register and bypass bit next-state.
  always_comb begin
    ir_d  = ir_q;
    byp_d = byp_q;
    case (state_s)
      ST_CAP_IR: ir_d  = IR_CAPTURE;
      ST_SH_IR:  ir_d  = {TDI, ir_q[IR_W-1:1]};
      ST_CAP_DR: byp_d = 1'b0;
      ST_SH_DR:  byp_d = TDI;
      default: begin
        ir_d  = ir_q;
        byp_d = byp_q;
      end
    endcase
  end

  // Rising-edge scan registers.
  always_ff @(posedge TCK or negedge Reset) begin
    if (!Reset) begin
      ir_q  <= OP_BYPASS;
      byp_q <= 1'b0;
    end else begin
      ir_q  <= ir_d;
      byp_q <= byp_d;
    end
  end

  // Instruction latch: loads in Update-IR, falls back to BYPASS in Test-Logic-Reset.
  always_comb begin
    instr_d = instr_q;
    mode_d  = mode_q;
    if (state_s == ST_TLR) begin
      instr_d = OP_BYPASS;
      mode_d  = 1'b0;
    end else if (state_s == ST_UPD_IR) begin
      instr_d = ir_q;
      mode_d  = (ir_q == OP_EXTEST);
    end else begin
      instr_d = instr_q;
      mode_d  = mode_q;
    end
  end

  // TDO source select.
  always_comb begin
    tdo_d = 1'b0;
    if (state_s == ST_SH_IR) begin
      tdo_d = ir_q[0];
    end else if (in_sh_dr_s && br_sel_s) begin
      tdo_d = BR_TDO;
    end else if (in_sh_dr_s) begin
      tdo_d = byp_q;
    end else begin
      tdo_d = 1'b0;
    end
  end

  assign tdo_en_d = is_shift_state(state_s);

  // The gate enable is sampled at the falling edge, so it is stable for the
  // whole high phase of TCK and ClockBR cannot glitch.
  assign clk_en_d = br_sel_s && ((state_s == ST_CAP_DR) || (state_s == ST_SH_DR));

  // Falling-edge registers: instruction, mode, TDO and clock-gate enable.
  always_ff @(negedge TCK or negedge Reset) begin
    if (!Reset) begin
      instr_q  <= OP_BYPASS;
      mode_q   <= 1'b0;
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
      clk_en_q <= 1'b0;
    end else begin
      instr_q  <= instr_d;
      mode_q   <= mode_d;
      tdo_q    <= tdo_d;
      tdo_en_q <= tdo_en_d;
      clk_en_q <= clk_en_d;
    end
  end

  assign TDO      = tdo_q;
  assign TDO_En   = tdo_en_q;
  assign ShiftBR  = br_sel_s & in_sh_dr_s;
  assign ClockBR  = TCK & clk_en_q;
  assign UpdateBR = ~TCK & br_sel_s & (state_s == ST_UPD_DR);
  assign ModeCont = mode_q;
  assign TapState = state_s;

endmodule
